// File: rtl/beep_sequencer.sv
// beep_sequencer: queues (mode, duration) notes from the CPU and plays them
// back-to-back on the beep mode bus, with a silent gap after every note.
module beep_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TICK_DIV   = 1250000,
  parameter int unsigned GAP_CYCLES = 625000
) (
  input  logic        clk_125mhz,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        clr,
  output logic [7:0]  mode,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic [8:0]  level,
  output logic        overflow
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_MAX = (TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] TickLast = CW'(TICK_DIV - 1);
  // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
  localparam logic [CW-1:0] GapLast  = CW'(GAP_CYCLES - 1);
  localparam logic [8:0]    LevelMax = 9'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;

  state_e          state_q;
  logic [15:0]     note_q;
  logic [7:0]      tick_q;
  logic [CW-1:0]   cyc_q;
  logic [7:0]      mode_q;

  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [8:0]      level_q;
  logic            overflow_q;
  logic            wr_q;

  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic [7:0]      dur_last;

  // Push/pop decode; full is taken from the registered level, so a same-cycle pop
  // cannot make room for a push.
  always_comb begin
    push_req = wr_en & ~wr_q;
    push_ok  = push_req & ~full & ~clr;
    pop      = (state_q == StIdle) & ~empty & ~clr;
    dur_last = note_q[15:8] - 8'd1;
  end

  // Rising-edge detect on the slower-domain write strobe.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_en;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_125mhz) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        level_q <= level_q + 9'd1;
      end else if (!push_ok && pop) begin
        level_q <= level_q - 9'd1;
      end
      if (push_req && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Playback FSM with registered mode output.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      note_q  <= '0;
      tick_q  <= '0;
      cyc_q   <= '0;
      mode_q  <= '0;
    end else if (clr) begin
      state_q <= StIdle;
      tick_q  <= '0;
      cyc_q   <= '0;
      mode_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mode_q <= '0;
          if (!empty) begin
            note_q  <= mem_q[rd_ptr_q];
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (note_q[15:8] == 8'd0) begin
            state_q <= StIdle;
          end else begin
            mode_q  <= note_q[7:0];
            tick_q  <= '0;
            cyc_q   <= '0;
            state_q <= StPlay;
          end
        end
        StPlay: begin
          if (cyc_q == TickLast) begin
            cyc_q <= '0;
            if (tick_q == dur_last) begin
              mode_q  <= '0;
              state_q <= (GAP_CYCLES == 0) ? StIdle : StGap;
            end else begin
              tick_q <= tick_q + 8'd1;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        StGap: begin
          if (cyc_q == GapLast) begin
            cyc_q   <= '0;
            state_q <= StIdle;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    full     = (level_q == LevelMax);
    empty    = (level_q == 9'd0);
    busy     = (state_q != StIdle) | ~empty;
    level    = level_q;
    overflow = overflow_q;
    mode     = mode_q;
  end

endmodule
